// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer.
//
// Time-shares one external full adder across a WIDTH-bit operand pair,
// one bit per clock, LSB first. A front-end requests an operation with
// start; busy is high while bits are being processed, done pulses for one
// cycle when result/ovf have been updated.
//
// Ports:
//   mclk     system clock, all state changes on the rising edge
//   rs       synchronous active-high reset
//   start    operation request, sampled only while idle
//   sub      0 = A+B, 1 = A-B, captured with the operands
//   a_in     operand A, captured on the accepting edge
//   b_in     operand B, captured on the accepting edge
//   fa_a     to full_adder .a
//   fa_b     to full_adder .b
//   fa_cin   to full_adder .cin
//   fa_sum   from full_adder .sum
//   fa_cout  from full_adder .cout
//   busy     high while bits are being processed
//   done     one-cycle pulse, result valid
//   result   [WIDTH-1:0] sum/difference, [WIDTH] carry (add) or borrow (sub)
//   ovf      signed two's-complement overflow of the last operation
module serial_add_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             mclk,
  input  logic             rs,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             ovf_q, ovf_d;
  // fa_sum joined on top of the result shifter; the upper WIDTH bits are
  // the shifted value (written this way so WIDTH=1 needs no special case)
  logic [WIDTH:0]   res_cat_s;

  // Full-adder operand drive: only meaningful while running, zero otherwise
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == S_RUN) begin
      fa_a   = a_sh_q[0];
      fa_b   = b_sh_q[0] ^ sub_q;
      fa_cin = carry_q;
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  // Next-state and datapath computation for the sequencer
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_sh_d  = res_sh_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    res_cat_s = {fa_sum, res_sh_q};

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (start) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          res_sh_d = '0;
          sub_d    = sub;
          // subtraction is A + ~B + 1: the +1 enters as the initial carry
          carry_d  = sub;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = res_cat_s[WIDTH:1];
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // carry_q is the carry into the MSB stage on this last bit
          result_d = {(sub_q ? ~fa_cout : fa_cout), res_cat_s[WIDTH:1]};
          ovf_d    = carry_q ^ fa_cout;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge mclk) begin
    if (rs) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule
